id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised decode stage with an internal multi-port register file, a pending-write scoreboard and a registered `id_ex` output under a valid/ready handshake. It sits between the fetch pipeline register (`if_id`) and execute. It replaces the single-cycle, always-enabled decoder with a stage that stalls on read-after-write and write-after-write hazards. It bypasses same-cycle write-backs and supports a pipeline flush.

## Interface
Parameters:
- `NUM_WB`, 2: number of write-back ports (1..4).
- `NREGS`, 32: architectural registers; `reg_addr` indexes them.
- `BYPASS`, 1: 1 enables write-through of same-cycle write-back data into the read path.
- `CNT_W`, 32: width of the stall-cycle performance counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `if_id_state` in `if_id`: fetched instruction, PC and signal.
- `in_valid` in 1: `if_id_state` holds a live instruction.
- `in_ready` out 1: stage accepts `if_id_state` this cycle.
- `id_ex_state` out `id_ex`: registered decoded instruction.
- `out_valid` out 1: `id_ex_state` is live.
- `out_ready` in 1: execute consumes `id_ex_state` this cycle.
- `wb_valid` in `NUM_WB`: per-port write-back enable.
- `wb_addr` in `NUM_WB` x `reg_addr`: write-back destination.
- `wb_data` in `NUM_WB` x `word_t`: write-back value.
- `flush` in 1: squash the stage contents and clear the scoreboard.
- `regs_value` out `NREGS` x `word_t`: architectural register state, for difftest.
- `stall_cycles` out `CNT_W`: count of hazard-stall cycles.

## Operation
- Source use:
  - rs1 is used except for LUI, AUIPC and JAL.
  - rs2 is used for R-type, S-type and B-type.
  - Reads of x0 always return 0 and never hazard.
- Destination: `inst[11:7]`. `reg_write_enable` is 0 for S-type, B-type and for rd = x0; otherwise it is 1.
- Scoreboard: one pending bit per register.
  - Set on accept of an instruction with `reg_write_enable`.
  - Cleared by any `wb_valid[i]` whose `wb_addr[i]` matches.
  - If set and clear hit the same register in one cycle, set wins.
- Hazard, which is a stall:
  - A used source is pending and not matched by a same-cycle `wb_valid` when `BYPASS`=1 (RAW).
  - The destination is pending and `reg_write_enable` is 1 (WAW).
- `in_ready` = `!hazard && (!out_valid || out_ready)`. Accept when `in_valid && in_ready`.
- `stall_cycles` increments by 1 in each cycle where `in_valid && hazard`. It wraps at 2^`CNT_W`.
- Register file:
  - Written at the clock edge for each `wb_valid[i]` with `wb_addr[i]` != 0.
  - If two ports write the same register, the highest index wins.
  - When `BYPASS`=1, a read sees same-cycle write-back data, again with the highest index winning.
- `flush` has priority over accept:
  - Next cycle `out_valid`=0, the scoreboard is all zero and nothing is accepted.
  - Register-file writes in the flush cycle still happen.
  - `flush` is asserted only when no surviving older instruction has a write-back outstanding; this is a controller contract.

## Timing
- Reset: `out_valid`=0, `id_ex_state`=0, all registers 0, scoreboard 0, `stall_cycles`=0. `in_ready` follows from these.
- Latency: an instruction accepted in cycle N appears with `out_valid`=1 in cycle N+1.
- `out_valid && !out_ready` holds `id_ex_state` stable.
- `out_valid && out_ready` with no new accept drops `out_valid` in the next cycle.
- Consume and accept in the same cycle gives full throughput, one instruction per cycle.
- Write-back to register file: written at the edge, visible to combinational reads in the next cycle, or in the same cycle when `BYPASS`=1.
- Register-file reads and hazard evaluation are combinational from `if_id_state`. There is no combinational path from `out_ready` to `id_ex_state`.
- Reset mid-stall discards the held instruction and all pending bits.

## Structure
- Shared package `common`:
  - `id_ex` gains `reg_write_enable`, `rs1_used` and `rs2_used`.
  - Add an `OPC_*` opcode constant set used for source-use decode.
- Sub-module `regfile_mp`: holds the `NREGS` x `word_t` array with `NUM_WB` write ports, two bypassed read ports and the full-array `regs_value` output.
- Scoreboard, handshake register and counter live in `id_stage_pipe`.
- Immediate/op decode reuses the existing arithmetic decoder as-is.

## Test plan
- Reset, then `addi x1,x0,5` with `in_valid`=1 and `out_ready`=1:
  - Next cycle `out_valid`=1, `reg_dest_addr`=1, `reg_write_enable`=1.
  - x1 is pending.
- RAW stall:
  - Issue `addi x1,x0,5`, then `add x2,x1,x1`: `in_ready`=0 and `stall_cycles` increments by 1 per cycle.
  - Then `wb_valid[0]`=1, `wb_addr`=1, `wb_data`=5 in cycle K: `add` is accepted in K with `BYPASS`=1, and `reg1_value`=`reg2_value`=5.
- WAW: `addi x3` pending, then `addi x3,x0,7` stalls until x3 is written back. `sw x3` does not set pending.
- Backpressure: `out_ready`=0 for 3 cycles with a valid output → `id_ex_state` is unchanged and `in_ready`=0. Then `out_ready`=1 → one instruction per cycle.
- Dual write-back, `NUM_WB`=2:
  - Ports 0 and 1 write x5 = 1 and x5 = 2 in the same cycle → x5 = 2 and x5 is not pending.
  - A write to x0 leaves x0 = 0.
- Flush with `out_valid`=1 and x1, x4 pending → next cycle `out_valid`=0, scoreboard 0, and `add x2,x1,x4` is accepted immediately.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: shared types, opcode constants and immediate decoder for the decode stage
package id_stage_pipe_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0] reg_addr;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef struct packed {
    word_t inst;
    word_t pc;
  } if_id;
  typedef struct packed {
    word_t   pc;
    word_t   inst;
    word_t   imm;
    word_t   reg1_value;
    word_t   reg2_value;
    reg_addr reg_dest_addr;
    logic    reg_write_enable;
    logic    rs1_used;
    logic    rs2_used;
  } id_ex;
  function automatic word_t decode_imm(word_t inst);
    logic [6:0] opc;
    opc = inst[6:0];
    return (opc == OPC_LUI || opc == OPC_AUIPC) ? {inst[31:12], 12'b0} :
           opc == OPC_JAL    ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
           opc == OPC_BRANCH ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
           opc == OPC_STORE  ? {{21{inst[31]}}, inst[30:25], inst[11:7]} :
                               {{21{inst[31]}}, inst[30:20]};
  endfunction
endpackage

// File: rtl/id_stage_pipe_regfile_mp.sv
// regfile_mp: multi-write-port register file with two optionally bypassed read ports
module regfile_mp
  import id_stage_pipe_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  reg_addr [NUM_WB-1:0]    wb_addr,
  input  word_t [NUM_WB-1:0]      wb_data,
  input  reg_addr                 ra1,
  input  reg_addr                 ra2,
  output word_t                   rd1,
  output word_t                   rd2,
  output word_t [NREGS-1:0]       regs_value
);
  word_t [NREGS-1:0] regs;
  assign regs_value = regs;
  // ascending loop makes the highest port index win on collisions
  always_ff @(posedge clk) begin
    if (rst) regs <= '0;
    else
      for (int i = 0; i < NUM_WB; i++)
        if (wb_valid[i] && wb_addr[i] != '0) regs[wb_addr[i]] <= wb_data[i];
  end
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    for (int i = 0; i < NUM_WB; i++) begin
      if (BYPASS != 0 && wb_valid[i] && wb_addr[i] == ra1) rd1 = wb_data[i];
      if (BYPASS != 0 && wb_valid[i] && wb_addr[i] == ra2) rd2 = wb_data[i];
    end
    rd1 = ra1 == '0 ? '0 : rd1;
    rd2 = ra2 == '0 ? '0 : rd2;
  end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with scoreboard hazard stalls, bypassed regfile and registered id_ex handshake
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  if_id                 if_id_state,
  input  logic                 in_valid,
  output logic                 in_ready,
  output id_ex                 id_ex_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  reg_addr [NUM_WB-1:0] wb_addr,
  input  word_t [NUM_WB-1:0]   wb_data,
  input  logic                 flush,
  output word_t [NREGS-1:0]    regs_value,
  output logic [CNT_W-1:0]     stall_cycles
);
  logic [NREGS-1:0] pend, pend_n;
  logic [6:0] opc;
  reg_addr rs1, rs2, rd;
  logic rs1_used, rs2_used, we, hit1, hit2, hazard, accept;
  word_t rd1, rd2;
  id_ex dec;
  assign opc = if_id_state.inst[6:0];
  assign rs1 = if_id_state.inst[19:15];
  assign rs2 = if_id_state.inst[24:20];
  assign rd  = if_id_state.inst[11:7];
  assign rs1_used = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign rs2_used = opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH;
  assign we = !(opc == OPC_STORE || opc == OPC_BRANCH) && rd != '0;
  regfile_mp #(.NUM_WB(NUM_WB), .NREGS(NREGS), .BYPASS(BYPASS)) u_rf (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ra1(rs1), .ra2(rs2), .rd1(rd1), .rd2(rd2), .regs_value(regs_value)
  );
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      hit1 = hit1 | (wb_valid[i] && wb_addr[i] == rs1);
      hit2 = hit2 | (wb_valid[i] && wb_addr[i] == rs2);
    end
  end
  // x0 never becomes pending, so x0 sources need no explicit exemption
  assign hazard = (rs1_used && pend[rs1] && !(BYPASS != 0 && hit1)) ||
                  (rs2_used && pend[rs2] && !(BYPASS != 0 && hit2)) ||
                  (we && pend[rd]);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept = in_valid && in_ready && !flush;
  always_comb begin
    pend_n = pend;
    for (int i = 0; i < NUM_WB; i++)
      if (wb_valid[i]) pend_n[wb_addr[i]] = 1'b0;
    if (accept && we) pend_n[rd] = 1'b1;
    pend_n = flush ? '0 : pend_n;
  end
  always_comb begin
    dec = '0;
    dec.pc = if_id_state.pc;
    dec.inst = if_id_state.inst;
    dec.imm = decode_imm(if_id_state.inst);
    dec.reg1_value = rd1;
    dec.reg2_value = rd2;
    dec.reg_dest_addr = rd;
    dec.reg_write_enable = we;
    dec.rs1_used = rs1_used;
    dec.rs2_used = rs2_used;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      out_valid <= 1'b0;
      id_ex_state <= '0;
      stall_cycles <= '0;
    end else begin
      pend <= pend_n;
      if (in_valid && hazard) stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush) out_valid <= 1'b0;
      else if (accept) begin
        out_valid <= 1'b1;
        id_ex_state <= dec;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed checks of hazards, bypass, backpressure, flush and reset
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, flush = 0;
  if_id if_id_state = '0;
  id_ex id_ex_state;
  logic [1:0] wb_valid = '0;
  reg_addr [1:0] wb_addr = '0;
  word_t [1:0] wb_data = '0;
  word_t [31:0] regs_value;
  logic [31:0] stall_cycles;
  int total = 0, passed = 0;
  id_stage_pipe #(.NUM_WB(2), .NREGS(32), .BYPASS(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_id_state(if_id_state), .in_valid(in_valid), .in_ready(in_ready),
    .id_ex_state(id_ex_state), .out_valid(out_valid), .out_ready(out_ready), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .regs_value(regs_value),
    .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  function automatic word_t addi(int rd, int rs1, int imm);
    return word_t'((imm & 12'hfff) << 20 | rs1 << 15 | rd << 7 | 32'h13);
  endfunction
  function automatic word_t add(int rd, int rs1, int rs2);
    return word_t'(rs2 << 20 | rs1 << 15 | rd << 7 | 32'h33);
  endfunction
  function automatic word_t sw(int rs2, int rs1);
    return word_t'(rs2 << 20 | rs1 << 15 | 2 << 12 | 32'h23);
  endfunction
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input word_t inst);
    in_valid = 1;
    if_id_state.inst = inst;
    if_id_state.pc = if_id_state.pc + 4;
    #1;
  endtask
  task automatic wb(input logic [1:0] v, input int a0, input word_t d0, input int a1, input word_t d1);
    wb_valid = v;
    wb_addr[0] = reg_addr'(a0);
    wb_data[0] = d0;
    wb_addr[1] = reg_addr'(a1);
    wb_data[1] = d1;
    #1;
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_state_zero", id_ex_state === '0, 1);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_regs_zero", regs_value === '0, 1);
    chk("rst_in_ready", in_ready, 1);
    drive(addi(1, 0, 5));
    chk("addi_in_ready", in_ready, 1);
    tick();
    chk("addi_out_valid", out_valid, 1);
    chk("addi_rd", id_ex_state.reg_dest_addr, 1);
    chk("addi_we", id_ex_state.reg_write_enable, 1);
    chk("addi_imm", id_ex_state.imm, 5);
    drive(add(2, 1, 1));
    chk("raw_in_ready", in_ready, 0);
    tick();
    chk("raw_stall1", stall_cycles, 1);
    chk("raw_drained", out_valid, 0);
    tick();
    chk("raw_stall2", stall_cycles, 2);
    wb(2'b01, 1, 5, 0, 0);
    chk("raw_bypass_ready", in_ready, 1);
    tick();
    wb(2'b00, 0, 0, 0, 0);
    chk("raw_out_valid", out_valid, 1);
    chk("raw_reg1", id_ex_state.reg1_value, 5);
    chk("raw_reg2", id_ex_state.reg2_value, 5);
    chk("raw_rd", id_ex_state.reg_dest_addr, 2);
    chk("raw_stall_held", stall_cycles, 2);
    chk("raw_x1", regs_value[1], 5);
    drive(addi(3, 0, 1));
    tick();
    drive(addi(3, 0, 7));
    chk("waw_in_ready", in_ready, 0);
    tick();
    wb(2'b10, 0, 0, 3, 9);
    chk("waw_wb_cycle_ready", in_ready, 0);
    tick();
    wb(2'b00, 0, 0, 0, 0);
    chk("waw_stall", stall_cycles, 4);
    chk("waw_released", in_ready, 1);
    tick();
    chk("waw_imm", id_ex_state.imm, 7);
    chk("waw_x3", regs_value[3], 9);
    drive(sw(3, 0));
    wb(2'b01, 3, 7, 0, 0);
    chk("sw_ready", in_ready, 1);
    tick();
    wb(2'b00, 0, 0, 0, 0);
    chk("sw_we", id_ex_state.reg_write_enable, 0);
    chk("sw_reg2", id_ex_state.reg2_value, 7);
    drive(addi(3, 0, 2));
    chk("sw_no_pending", in_ready, 1);
    tick();
    out_ready = 0;
    drive(addi(4, 0, 4));
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_imm_held", id_ex_state.imm, 2);
      chk("bp_rd_held", id_ex_state.reg_dest_addr, 3);
    end
    chk("bp_no_stall", stall_cycles, 4);
    out_ready = 1;
    tick();
    chk("tp_rd4", id_ex_state.reg_dest_addr, 4);
    drive(addi(6, 0, 6));
    tick();
    chk("tp_rd6", id_ex_state.reg_dest_addr, 6);
    chk("tp_valid", out_valid, 1);
    drive(addi(5, 0, 0));
    tick();
    in_valid = 0;
    wb(2'b11, 5, 1, 5, 2);
    tick();
    wb(2'b00, 0, 0, 0, 0);
    chk("dual_x5", regs_value[5], 2);
    drive(addi(5, 0, 1));
    chk("dual_x5_clear", in_ready, 1);
    tick();
    drive(add(9, 5, 0));
    wb(2'b11, 5, 32'ha, 5, 32'h14);
    chk("dual_bypass_ready", in_ready, 1);
    tick();
    chk("dual_bypass_reg1", id_ex_state.reg1_value, 32'h14);
    chk("dual_bypass_reg2", id_ex_state.reg2_value, 0);
    chk("dual_x5_b", regs_value[5], 32'h14);
    in_valid = 0;
    wb(2'b01, 0, 32'hdead, 0, 0);
    tick();
    wb(2'b00, 0, 0, 0, 0);
    chk("x0_zero", regs_value[0], 0);
    drive(addi(1, 0, 3));
    tick();
    drive(add(2, 1, 4));
    flush = 1;
    wb(2'b01, 4, 32'h44, 0, 0);
    chk("flush_hazard", in_ready, 0);
    tick();
    flush = 0;
    wb(2'b00, 0, 0, 0, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sb_clear", in_ready, 1);
    chk("flush_wb_x4", regs_value[4], 32'h44);
    chk("flush_stall", stall_cycles, 5);
    tick();
    chk("flush_accept", out_valid, 1);
    chk("flush_rd", id_ex_state.reg_dest_addr, 2);
    chk("flush_reg1", id_ex_state.reg1_value, 5);
    chk("flush_reg2", id_ex_state.reg2_value, 32'h44);
    drive(add(10, 2, 0));
    chk("rs_stall_ready", in_ready, 0);
    tick();
    chk("rs_stall_cnt", stall_cycles, 6);
    rst = 1;
    tick();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_stall_zero", stall_cycles, 0);
    chk("rs_x1_zero", regs_value[1], 0);
    rst = 0;
    #1;
    chk("rs_in_ready", in_ready, 1);
    tick();
    chk("rs_accept", out_valid, 1);
    chk("rs_rd", id_ex_state.reg_dest_addr, 10);
    chk("rs_reg1", id_ex_state.reg1_value, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
